red_pitaya_sort_sched: RTL

Downstream stage of the droplet sorter. It converts each sort trigger into a delayed, fixed-length high-voltage gate and a one-cycle ASG start strobe. The delay covers droplet travel time from the detection spot to the sorting electrode. Up to 2^QAW triggers can be pending at once, so several droplets may be in flight between detector and electrode. Registers sit on the standard system bus at the module's 20-bit offset.

---
 rtl/red_pitaya_sort_sched_pkg.sv | 25 ++
 rtl/red_pitaya_sort_sched_fifo.sv | 66 ++++++
 rtl/red_pitaya_sort_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_sort_sched_pkg.sv
// rtl/red_pitaya_sort_sched_pkg.sv - register map, ctrl bit indices and reset defaults for the sort scheduler
package red_pitaya_sort_sched_pkg;

  // Register offsets within the module's 20-bit window
  localparam logic [19:0] REG_CTRL    = 20'h00;
  localparam logic [19:0] REG_DELAY   = 20'h04;
  localparam logic [19:0] REG_PULSE   = 20'h08;
  localparam logic [19:0] REG_STATUS  = 20'h10;
  localparam logic [19:0] REG_FIRED   = 20'h14;
  localparam logic [19:0] REG_DROPPED = 20'h18;
  localparam logic [19:0] REG_MERGED  = 20'h1C;

  // ctrl register bits
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // status register bits above the occupancy field
  localparam int STATUS_FULL_BIT = 16;
  localparam int STATUS_GATE_BIT = 17;

  // Reset defaults, in ADC clock cycles
  localparam int DELAY_RST = 125;
  localparam int PULSE_RST = 125;

endpackage

// File: rtl/red_pitaya_sort_sched_fifo.sv
// rtl/red_pitaya_sort_sched_fifo.sv - synchronous FIFO of pending absolute fire times
module sort_sched_fifo #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer next-state; flush discards everything including a same-cycle push
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/red_pitaya_sort_sched.sv
// rtl/red_pitaya_sort_sched.sv - turns sort triggers into delayed fixed-length HV gates and ASG start strobes
module red_pitaya_sort_sched
  import red_pitaya_sort_sched_pkg::*;
#(
  parameter int QAW = 3,
  parameter int TW  = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rstn_i,
  input  logic        sort_trig_i,
  output logic        gate_o,
  output logic        asg_trig_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  localparam logic [TW-1:0] ONE = TW'(1);

  logic [19:0]   addr;
  logic          trig_q, trig_prev_q;
  logic [TW-1:0] now_q;
  logic          enable_q;
  logic [TW-1:0] delay_q, pulse_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          asg_q;
  logic [TW-1:0] fired_q, fired_d;
  logic [TW-1:0] dropped_q, dropped_d;
  logic [TW-1:0] merged_q, merged_d;
  logic          ack_q;
  logic [31:0]   rdata_q, rd_mux;

  logic          edge_det, clear, flush, push, pop, drop, due;
  logic [TW-1:0] head, since_head, len_load;
  logic [QAW:0]  occ;
  logic          full, empty;
  logic          unused_bus;

  assign addr       = sys_addr[19:0];
  assign unused_bus = ^{sys_sel, sys_addr[31:20]};

  assign edge_det = trig_q && !trig_prev_q;
  assign clear    = sys_wen && (addr == REG_CTRL) && sys_wdata[CTRL_CLR_BIT];
  assign flush    = !enable_q || clear;
  assign push     = edge_det && enable_q && !clear;

  // Wrap-safe due test: head is due once now has reached it (difference below half range)
  assign since_head = now_q - head;
  assign due        = !since_head[TW-1];
  assign pop        = enable_q && !clear && !empty && due;
  assign drop       = push && full && !pop;
  assign len_load   = (pulse_q == '0) ? ONE : pulse_q;

  assign gate_o     = (cnt_q != '0);
  assign asg_trig_o = asg_q;
  assign sys_rdata  = rdata_q;
  assign sys_ack    = ack_q;
  assign sys_err    = 1'b0;

  // Fire time is the timestamp at the push edge plus the programmed delay
  sort_sched_fifo #(
    .AW (QAW),
    .DW (TW)
  ) u_fifo (
    .clk_i   (adc_clk_i),
    .rstn_i  (adc_rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (now_q + ONE + delay_q),
    .data_o  (head),
    .count_o (occ),
    .full_o  (full),
    .empty_o (empty)
  );

  // Timestamp and trigger input synchroniser / edge history
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      now_q       <= '0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      now_q       <= now_q + ONE;
      trig_q      <= sort_trig_i;
      trig_prev_q <= trig_q;
    end
  end

  // Gate length counter and event counters; clear leaves an active gate running
  always_comb begin
    cnt_d     = cnt_q;
    fired_d   = fired_q;
    dropped_d = dropped_q;
    merged_d  = merged_q;
    if (!enable_q)          cnt_d = '0;
    else if (pop)           cnt_d = len_load;
    else if (cnt_q != '0)   cnt_d = cnt_q - ONE;
    if (clear) begin
      fired_d   = '0;
      dropped_d = '0;
      merged_d  = '0;
    end else begin
      if (pop)                       fired_d   = fired_q + ONE;
      if (pop && gate_o)             merged_d  = merged_q + ONE;
      if (drop && (dropped_q != '1)) dropped_d = dropped_q + ONE;
    end
  end

  // Gate state and counter registers
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      cnt_q     <= '0;
      asg_q     <= 1'b0;
      fired_q   <= '0;
      dropped_q <= '0;
      merged_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      asg_q     <= pop;
      fired_q   <= fired_d;
      dropped_q <= dropped_d;
      merged_q  <= merged_d;
    end
  end

  // Writable configuration registers; unmapped writes fall through
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      enable_q <= 1'b0;
      delay_q  <= TW'(DELAY_RST);
      pulse_q  <= TW'(PULSE_RST);
    end else if (sys_wen) begin
      case (addr)
        REG_CTRL:  enable_q <= sys_wdata[CTRL_EN_BIT];
        REG_DELAY: delay_q  <= TW'(sys_wdata);
        REG_PULSE: pulse_q  <= TW'(sys_wdata);
        default:   ;
      endcase
    end
  end

  // Read decode; clear bit always reads back as 0
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_CTRL:    rd_mux[CTRL_EN_BIT] = enable_q;
      REG_DELAY:   rd_mux = 32'(delay_q);
      REG_PULSE:   rd_mux = 32'(pulse_q);
      REG_STATUS: begin
        rd_mux[QAW:0]           = occ;
        rd_mux[STATUS_FULL_BIT] = full;
        rd_mux[STATUS_GATE_BIT] = gate_o;
      end
      REG_FIRED:   rd_mux = 32'(fired_q);
      REG_DROPPED: rd_mux = 32'(dropped_q);
      REG_MERGED:  rd_mux = 32'(merged_q);
      default:     rd_mux = '0;
    endcase
  end

  // Single-cycle acknowledge with registered read data
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= sys_wen || sys_ren;
      rdata_q <= sys_ren ? rd_mux : 32'd0;
    end
  end

endmodule
